// File: rtl/hazard_fwd_scoreboard_pkg.sv
// Shared constants and helpers for the forwarding/hazard scoreboard and the ID/EX register logic.
// Stage numbering: 0 = EX, 1 = MEM, ..., DEPTH = WB.
package hazard_fwd_scoreboard_pkg;

    localparam int unsigned DEF_RW        = 4;
    localparam int unsigned DEF_NUM_SRC   = 3;
    localparam int unsigned DEF_STORE_SRC = 1;
    localparam int unsigned DEF_DEPTH     = 2;
    localparam int unsigned DEF_CNT_W     = 16;

    localparam int unsigned STAGE_EX  = 0;
    localparam int unsigned STAGE_MEM = 1;
    localparam int unsigned STAGE_MWB = 2;

    // Select width: 0 = register file, 1..depth = forwarding stage.
    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_scoreboard_fwd_match.sv
// Matches one EX source register against the post-EX writer tags and
// returns the nearest forwarding stage (0 when the register file is current).
module fwd_match
    import hazard_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned RW    = DEF_RW,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned SW    = sel_width(DEPTH)
) (
    input  logic                      src_valid,
    input  logic [RW-1:0]             src,
    input  logic [DEPTH-1:0]          stg_wr,
    input  logic [DEPTH-1:0][RW-1:0]  stg_rd,
    output logic [SW-1:0]             sel
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        // Element 0 is stage 1 (MEM); scanning upward keeps the nearest writer.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && src_valid && (src != '0) && stg_wr[i] && (stg_rd[i] == src)) begin
                sel   = SW'(i + 1);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Forwarding/hazard unit: tracks instruction tags from EX to WB, drives EX operand
// forwarding selects, the load-use stall, MEM store-data forwarding and a stall counter.
module hazard_fwd_scoreboard
    import hazard_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned RW        = DEF_RW,
    parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
    parameter int unsigned STORE_SRC = DEF_STORE_SRC,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 hold,
    input  logic                                 flush,
    input  logic                                 id_valid,
    input  logic [RW-1:0]                        id_rd,
    input  logic                                 id_regwrite,
    input  logic                                 id_memread,
    input  logic                                 id_memwrite,
    input  logic [NUM_SRC*RW-1:0]                id_src,
    input  logic [NUM_SRC-1:0]                   id_src_used,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]   fwd_sel,
    output logic                                 load_use_stall,
    output logic                                 dmem_fwd,
    output logic [CNT_W-1:0]                     stall_cnt
);

    localparam int unsigned SW = sel_width(DEPTH);

    // Only the fields a later stage actually consumes are carried past EX/MEM.
    logic [DEPTH:0]                  vld_q, vld_d;
    logic [DEPTH:0]                  wr_q, wr_d;
    logic [DEPTH:0][RW-1:0]          rd_q, rd_d;
    logic                            mr_q, mr_d;
    logic [STAGE_MEM:0]              mw_q, mw_d;
    logic [NUM_SRC-1:0][RW-1:0]      src0_q, src0_d;
    logic [NUM_SRC-1:0]              used0_q, used0_d;
    logic [RW-1:0]                   st_src1_q, st_src1_d;
    logic                            st_used1_q, st_used1_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    logic [NUM_SRC-1:0][RW-1:0]      id_src_a;
    logic                            t0_load;
    logic                            src_hit;
    logic                            id_take;
    logic [DEPTH-1:0]                stg_wr;
    logic [DEPTH-1:0][RW-1:0]        stg_rd;

    assign id_src_a  = id_src;
    assign stall_cnt = cnt_q;
    assign stg_wr    = vld_q[DEPTH:1] & wr_q[DEPTH:1];
    assign stg_rd    = rd_q[DEPTH:1];

    always_comb begin
        t0_load = vld_q[STAGE_EX] & mr_q & wr_q[STAGE_EX] & (rd_q[STAGE_EX] != '0);
        src_hit = 1'b0;
        // Store data needed by a store is handled by dmem_fwd, so it never stalls.
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (id_src_used[j] && (id_src_a[j] == rd_q[STAGE_EX]) &&
                !((j == STORE_SRC) && id_memwrite)) begin
                src_hit = 1'b1;
            end
        end
        load_use_stall = id_valid & ~flush & t0_load & src_hit;
        id_take        = id_valid & ~flush & ~load_use_stall;
    end

    always_comb begin
        dmem_fwd = vld_q[STAGE_MEM] & mw_q[STAGE_MEM] & st_used1_q &
                   vld_q[STAGE_MWB] & wr_q[STAGE_MWB] &
                   (rd_q[STAGE_MWB] == st_src1_q) & (st_src1_q != '0);
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_match #(
            .RW    (RW),
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_match (
            .src_valid (vld_q[STAGE_EX] & used0_q[g]),
            .src       (src0_q[g]),
            .stg_wr    (stg_wr),
            .stg_rd    (stg_rd),
            .sel       (fwd_sel[g*SW +: SW])
        );
    end

    always_comb begin
        vld_d      = vld_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        mr_d       = mr_q;
        mw_d       = mw_q;
        src0_d     = src0_q;
        used0_d    = used0_q;
        st_src1_d  = st_src1_q;
        st_used1_d = st_used1_q;
        cnt_d      = cnt_q;

        if (!hold) begin
            for (int unsigned i = 1; i <= DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                wr_d[i]  = wr_q[i-1];
                rd_d[i]  = rd_q[i-1];
            end
            mw_d[STAGE_MEM] = mw_q[STAGE_EX];
            st_src1_d       = src0_q[STORE_SRC];
            st_used1_d      = used0_q[STORE_SRC];

            if (id_take) begin
                vld_d[STAGE_EX] = 1'b1;
                wr_d[STAGE_EX]  = id_regwrite;
                rd_d[STAGE_EX]  = id_rd;
                mr_d            = id_memread;
                mw_d[STAGE_EX]  = id_memwrite;
                src0_d          = id_src_a;
                used0_d         = id_src_used;
            end else begin
                vld_d[STAGE_EX] = 1'b0;
                wr_d[STAGE_EX]  = 1'b0;
                rd_d[STAGE_EX]  = '0;
                mr_d            = 1'b0;
                mw_d[STAGE_EX]  = 1'b0;
                src0_d          = '0;
                used0_d         = '0;
            end

            if (load_use_stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            mr_q       <= 1'b0;
            mw_q       <= '0;
            src0_q     <= '0;
            used0_q    <= '0;
            st_src1_q  <= '0;
            st_used1_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            mr_q       <= mr_d;
            mw_q       <= mw_d;
            src0_q     <= src0_d;
            used0_q    <= used0_d;
            st_src1_q  <= st_src1_d;
            st_used1_q <= st_used1_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
